// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-bank C-port writeback controller.
// Writeback FSM encodings, default bus widths and the queue entry layout.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 5;

  typedef enum logic [1:0] {
    WB_IDLE    = 2'd0,
    WB_SETUP   = 2'd1,
    WB_STROBE  = 2'd2,
    WB_RELEASE = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic [WB_SEL_W-1:0]  dest;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of pending register writes (dest + data per entry).
// Exposes the raw entry storage and a per-slot valid mask for forwarding lookups.
module wb_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push,
  input  logic [SEL_W-1:0]                  push_dest,
  input  logic [DATA_W-1:0]                 push_data,
  input  logic                              pop,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(DEPTH):0]            count,
  output logic [$clog2(DEPTH)-1:0]          rd_ptr,
  output logic [DEPTH-1:0][SEL_W-1:0]       dest_arr,
  output logic [DEPTH-1:0][DATA_W-1:0]      data_arr,
  output logic [DEPTH-1:0]                  valid
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_q, wr_q;
  logic [PTR_W:0]   cnt_q;
  logic [PTR_W-1:0] off;

  // Pointers are PTR_W bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PTR_W'(1);
      if (pop)  rd_q <= rd_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dest_arr[wr_q] <= push_dest;
      data_arr[wr_q] <= push_data;
    end
  end

  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PTR_W'(i) - rd_q;
      valid[i] = ((PTR_W+1)'(off) < cnt_q);
    end
  end

  assign full   = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign count  = cnt_q;
  assign rd_ptr = rd_q;

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-bank C-port writeback initiator: queues results and replays each as a SETUP/STROBE/RELEASE write.
// Optional operand forwarding from queued entries is enabled by REG_WRITEBACK_CTRL_FORWARD_EN.
module reg_writeback_ctrl
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WB_DATA_W,
  parameter int SEL_W  = WB_SEL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic [SEL_W-1:0]  res_dest,
  output logic [DATA_W-1:0] busC,
  output logic [SEL_W-1:0]  busCsel,
  output logic              WriteC,
  output logic              wb_busy,
  input  logic [SEL_W-1:0]  fwdA_sel,
  input  logic [SEL_W-1:0]  fwdB_sel,
  output logic              fwdA_hit,
  output logic              fwdB_hit,
  output logic [DATA_W-1:0] fwdA_data,
  output logic [DATA_W-1:0] fwdB_data
);
  localparam int PTR_W = $clog2(DEPTH);

  wb_state_e                    state_q, state_d;
  logic [DATA_W-1:0]            busc_q, busc_d;
  logic [SEL_W-1:0]             sel_q, sel_d;
  logic                         writec_q, writec_d;
  logic                         push, pop, full, empty;
  logic [PTR_W:0]               count;
  logic [PTR_W-1:0]             rd_ptr, head_idx;
  logic [DEPTH-1:0][SEL_W-1:0]  dest_arr;
  logic [DEPTH-1:0][DATA_W-1:0] data_arr;
  logic [DEPTH-1:0]             valid;

  // Register 0 is hard-wired in the bank, so writes to it are acknowledged and dropped.
  assign res_ready = !full;
  assign push      = res_valid && !full && (res_dest != '0);
  assign pop       = (state_q == WB_RELEASE);

  wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SEL_W(SEL_W)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .push_dest(res_dest), .push_data(res_data),
    .pop(pop), .full(full), .empty(empty), .count(count), .rd_ptr(rd_ptr),
    .dest_arr(dest_arr), .data_arr(data_arr), .valid(valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= WB_IDLE;
      busc_q   <= '0;
      sel_q    <= '0;
      writec_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      busc_q   <= busc_d;
      sel_q    <= sel_d;
      writec_q <= writec_d;
    end
  end

  // RELEASE only chains into SETUP when an older entry already sits behind the head,
  // so the next head is always in storage, never a same-cycle push.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_IDLE:    if (!empty) state_d = WB_SETUP;
      WB_SETUP:   state_d = WB_STROBE;
      WB_STROBE:  state_d = WB_RELEASE;
      WB_RELEASE: state_d = (count > (PTR_W+1)'(1)) ? WB_SETUP : WB_IDLE;
      default:    state_d = WB_IDLE;
    endcase
  end

  always_comb begin
    head_idx = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    writec_d = (state_d == WB_STROBE);
    busc_d   = busc_q;
    sel_d    = sel_q;
    if (state_d == WB_SETUP) begin
      busc_d = data_arr[head_idx];
      sel_d  = dest_arr[head_idx];
    end
  end

  assign busC    = busc_q;
  assign busCsel = sel_q;
  assign WriteC  = writec_q;
  assign wb_busy = !empty || (state_q != WB_IDLE);

`ifdef REG_WRITEBACK_CTRL_FORWARD_EN
  logic [PTR_W-1:0] age_idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwdA_hit  = 1'b0;
    fwdB_hit  = 1'b0;
    fwdA_data = '0;
    fwdB_data = '0;
    age_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      age_idx = rd_ptr + PTR_W'(k);
      if (valid[age_idx] && (fwdA_sel != '0) && (dest_arr[age_idx] == fwdA_sel)) begin
        fwdA_hit  = 1'b1;
        fwdA_data = data_arr[age_idx];
      end
      if (valid[age_idx] && (fwdB_sel != '0) && (dest_arr[age_idx] == fwdB_sel)) begin
        fwdB_hit  = 1'b1;
        fwdB_data = data_arr[age_idx];
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwdA_sel, fwdB_sel, valid};
  assign fwdA_hit   = 1'b0;
  assign fwdB_hit   = 1'b0;
  assign fwdA_data  = '0;
  assign fwdB_data  = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed testbench for reg_writeback_ctrl with a behavioural register-bank model on the C port.
module tb_reg_writeback_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_dest;
  logic [31:0] busC;
  logic [4:0]  busCsel;
  logic        WriteC;
  logic        wb_busy;
  logic [4:0]  fwdA_sel, fwdB_sel;
  logic        fwdA_hit, fwdB_hit;
  logic [31:0] fwdA_data, fwdB_data;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          nwrites  = 0;
  int          hi_err   = 0;
  logic        wc_prev  = 1'b0;
  logic [31:0] bank   [32];
  logic [4:0]  wr_sel [64];
  logic [31:0] wr_data[64];
  int          wr_cyc [64];
  int          base;

  reg_writeback_ctrl #(.DEPTH(4), .DATA_W(32), .SEL_W(5)) dut (
    .clk(clk), .reset(reset), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_dest(res_dest), .busC(busC), .busCsel(busCsel),
    .WriteC(WriteC), .wb_busy(wb_busy), .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel),
    .fwdA_hit(fwdA_hit), .fwdB_hit(fwdB_hit), .fwdA_data(fwdA_data), .fwdB_data(fwdB_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Register bank: captures busC into busCsel on the strobe's rising edge.
  always @(posedge WriteC) begin
    bank[busCsel] = busC;
    if (nwrites < 64) begin
      wr_sel[nwrites]  = busCsel;
      wr_data[nwrites] = busC;
      wr_cyc[nwrites]  = cyc;
    end
    nwrites++;
  end

  always @(negedge clk) begin
    if (WriteC && wc_prev) hi_err++;
    wc_prev = WriteC;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [4:0] d, input logic [31:0] v);
    int   n   = 0;
    logic acc = 1'b0;
    res_valid = 1'b1;
    res_dest  = d;
    res_data  = v;
    while (!acc && n < 50) begin
      acc = res_ready;
      @(negedge clk);
      n++;
    end
    res_valid = 1'b0;
    if (!acc) chk("push_timeout", 64'(acc), 64'd1);
  endtask

  task automatic wait_writes(input int target);
    int n = 0;
    while (nwrites < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("write_count_reached", 64'(nwrites >= target), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (wb_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 64'(wb_busy), 64'd0);
  endtask

  task automatic check_seq(input int first, input int num, input logic [4:0] d0, input int gap);
    for (int i = 0; i < num; i++) begin
      chk($sformatf("order_sel_%0d", i), 64'(wr_sel[first+i]), 64'(d0 + 5'(i)));
      chk($sformatf("order_data_%0d", i), 64'(wr_data[first+i]), 64'(32'h100 + 32'(d0) + 32'(i)));
      if (gap > 0 && i > 0)
        chk($sformatf("strobe_gap_%0d", i), 64'(wr_cyc[first+i] - wr_cyc[first+i-1]), 64'(gap));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) bank[i] = '0;
    reset = 1'b0; res_valid = 1'b0; res_data = '0; res_dest = '0;
    fwdA_sel = '0; fwdB_sel = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Reset state
    chk("rst_busC", 64'(busC), 64'd0);
    chk("rst_busCsel", 64'(busCsel), 64'd0);
    chk("rst_WriteC", 64'(WriteC), 64'd0);
    chk("rst_ready", 64'(res_ready), 64'd1);
    chk("rst_busy", 64'(wb_busy), 64'd0);
    chk("rst_fwdA_hit", 64'(fwdA_hit), 64'd0);
    chk("rst_fwdA_data", 64'(fwdA_data), 64'd0);

    // Single write: SETUP, STROBE, RELEASE after the accept edge
    push(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_setup_sel", 64'(busCsel), 64'd5);
    chk("t1_setup_data", 64'(busC), 64'hDEADBEEF);
    chk("t1_setup_wc", 64'(WriteC), 64'd0);
    @(negedge clk);
    chk("t1_strobe_wc", 64'(WriteC), 64'd1);
    @(negedge clk);
    chk("t1_release_wc", 64'(WriteC), 64'd0);
    chk("t1_release_busy", 64'(wb_busy), 64'd1);
    @(negedge clk);
    chk("t1_idle_busy", 64'(wb_busy), 64'd0);
    chk("t1_nwrites", 64'(nwrites), 64'd1);
    chk("t1_bank5", 64'(bank[5]), 64'hDEADBEEF);

    // Destination 0 is swallowed
    push(5'd0, 32'h1234);
    chk("t2_busy_now", 64'(wb_busy), 64'd0);
    repeat (6) @(negedge clk);
    chk("t2_busy_later", 64'(wb_busy), 64'd0);
    chk("t2_nwrites", 64'(nwrites), 64'd1);
    chk("t2_busC_held", 64'(busC), 64'hDEADBEEF);
    chk("t2_busCsel_held", 64'(busCsel), 64'd5);

    // Back-to-back 1..5 through a 4-deep queue
    base = nwrites;
    for (int i = 1; i <= 5; i++) begin
      push(5'(i), 32'h100 + 32'(i));
      if (i == 4) chk("t3_ready_full", 64'(res_ready), 64'd0);
    end
    wait_writes(base + 5);
    wait_idle();
    check_seq(base, 5, 5'd1, 3);
    chk("t3_bank5", 64'(bank[5]), 64'h105);

    // Same destination twice; forwarding returns the younger value
    base = nwrites;
    fwdA_sel = 5'd7;
    fwdB_sel = 5'd0;
    push(5'd7, 32'hA);
    push(5'd7, 32'hB);
`ifdef REG_WRITEBACK_CTRL_FORWARD_EN
    chk("t4_hitA", 64'(fwdA_hit), 64'd1);
    chk("t4_dataA", 64'(fwdA_data), 64'hB);
`else
    chk("t4_hitA_off", 64'(fwdA_hit), 64'd0);
    chk("t4_dataA_off", 64'(fwdA_data), 64'd0);
`endif
    chk("t4_hitB", 64'(fwdB_hit), 64'd0);
    wait_writes(base + 1);
`ifdef REG_WRITEBACK_CTRL_FORWARD_EN
    chk("t4_hitA_mid", 64'(fwdA_hit), 64'd1);
    chk("t4_dataA_mid", 64'(fwdA_data), 64'hB);
`else
    chk("t4_hitA_mid_off", 64'(fwdA_hit), 64'd0);
`endif
    wait_writes(base + 2);
    wait_idle();
    chk("t4_hitA_after", 64'(fwdA_hit), 64'd0);
    chk("t4_dataA_after", 64'(fwdA_data), 64'd0);
    chk("t4_bank7", 64'(bank[7]), 64'hB);
    chk("t4_first_write", 64'(wr_data[base]), 64'hA);
    fwdA_sel = '0;

    // Reset during STROBE with a second entry queued
    base = nwrites;
    push(5'd9, 32'h11);
    push(5'd10, 32'h22);
    begin
      int n = 0;
      while (!WriteC && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t5_in_strobe", 64'(WriteC), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("t5_wc_low", 64'(WriteC), 64'd0);
    chk("t5_busy", 64'(wb_busy), 64'd0);
    chk("t5_ready", 64'(res_ready), 64'd1);
    chk("t5_busC", 64'(busC), 64'd0);
    repeat (12) @(negedge clk);
    chk("t5_nwrites", 64'(nwrites), 64'(base + 1));
    chk("t5_bank9", 64'(bank[9]), 64'h11);
    chk("t5_bank10", 64'(bank[10]), 64'd0);

    // Sustained pushes against a full queue, wrapping the pointers twice
    base = nwrites;
    for (int i = 11; i <= 19; i++) push(5'(i), 32'h100 + 32'(i));
    wait_writes(base + 9);
    wait_idle();
    repeat (4) @(negedge clk);
    chk("t6_nwrites", 64'(nwrites), 64'(base + 9));
    check_seq(base, 9, 5'd11, 0);
    chk("t6_bank19", 64'(bank[19]), 64'h113);
    chk("strobe_width", 64'(hi_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/reg_writeback_ctrl.md
Name: reg_writeback_ctrl

Overview:
- Write-side initiator for the register bank's C port.
- Accepts results from execute/memory stages over a valid/ready handshake and buffers them in a small in-order queue.
- Replays each result as a safe busC/busCsel/WriteC sequence: data stable before the WriteC rising edge, and WriteC low between writes.
- Optionally answers operand-forwarding queries for results still queued.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- DATA_W, 32, result/busC width.
- SEL_W, 5, register select width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- res_valid  in  1  producer offers a result.
- res_ready  out  1  block can accept; equals !full.
- res_data  in  [0:DATA_W-1]  result value.
- res_dest  in  [0:SEL_W-1]  destination register.
- busC  out  [0:DATA_W-1]  write data to the register bank.
- busCsel  out  [0:SEL_W-1]  write select to the register bank.
- WriteC  out  1  write strobe; the bank writes on its rising edge.
- wb_busy  out  1  queue non-empty or FSM not IDLE.
- fwdA_sel, fwdB_sel  in  [0:SEL_W-1]  forwarding query selects (FORWARD_EN only).
- fwdA_hit, fwdB_hit  out  1  a queued write targets the queried register.
- fwdA_data, fwdB_data  out  [0:DATA_W-1]  youngest matching queued value.

Behaviour:
- Reset (reset=0 at a clk edge):
  - Queue flushed, count=0, FSM to IDLE.
  - busC=0, busCsel=0, WriteC=0, res_ready=1, wb_busy=0, fwd*_hit=0, fwd*_data=0.
  - Reset mid-sequence aborts the sequence. If the strobe was already high, the write already happened; no second write is issued.
- Accept: a transfer occurs when res_valid && res_ready at a clk edge.
  - res_dest==0: the result is accepted and discarded (not enqueued), because the bank ignores register 0.
  - res_dest!=0: the result is enqueued at the tail.
- res_ready depends only on registered count (!full). A pop in the same cycle does not raise ready in that cycle.
- FSM states: IDLE, SETUP, STROBE, RELEASE.
  - IDLE: if count>0, next SETUP.
  - SETUP: register busC/busCsel from the queue head; WriteC=0.
  - STROBE: WriteC=1; busC/busCsel held.
  - RELEASE: WriteC=0; busC/busCsel held; head popped at the end of this cycle. Next SETUP if count after pop >0, else IDLE.
- Timing:
  - Throughput is one write per 3 cycles.
  - Latency from accept into an empty idle block to the WriteC rise is 3 edges: accept edge, SETUP edge, STROBE edge.
- WriteC is registered, glitch-free, and high for exactly 1 cycle per write. Consecutive strobes are separated by at least 2 low cycles.
- busC/busCsel keep their last values in IDLE.
- Writes reach the bank strictly in acceptance order; the same destination written twice keeps the last value.
- Push and pop in the same cycle (RELEASE plus accept): count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- wb_busy = (count!=0) || (state!=IDLE).

Optional Feature:
- Macro: REG_WRITEBACK_CTRL_FORWARD_EN.
- Defined:
  - fwdX_hit is combinational: 1 if any valid queue entry, including the head in SETUP/STROBE/RELEASE, has dest==fwdX_sel and fwdX_sel!=0.
  - fwdX_data is the youngest such entry's data, else 0.
  - An entry is visible from the cycle after its accept until the cycle after its RELEASE.
- Undefined: fwd* inputs ignored; hit and data outputs tied 0; no comparators synthesized.

Decomposition:
- Package wb_pkg:
  - state enum/localparams: WB_IDLE=2'd0, WB_SETUP=2'd1, WB_STROBE=2'd2, WB_RELEASE=2'd3.
  - default DATA_W/SEL_W constants.
  - entry struct {dest, data}.
- Sub-module wb_fifo:
  - parameterized circular buffer with push/pop/count/full/empty.
  - exposes the entry array and valid mask for forwarding.
- Top level holds the FSM, output registers and forwarding priority logic.

Test Plan:
- Reset then a single push (dest=5, data=0xDEADBEEF) -> busCsel=5 and busC=0xDEADBEEF one cycle before WriteC rises; WriteC high exactly 1 cycle, 3 edges after accept; wb_busy falls after RELEASE.
- Push dest=0, data=0x1234 -> accepted, WriteC never rises, wb_busy stays 0.
- Back-to-back pushes to 1,2,3,4,5 with DEPTH=4 -> res_ready drops after 4 entries; writes emitted in order 1..5 with the correct data; strobes exactly 3 cycles apart.
- Push dest=7 (0xA) then dest=7 (0xB) with FORWARD_EN, query fwdA_sel=7 -> hit=1, data=0xB until the second RELEASE; the bank's final r7=0xB; fwdB_sel=0 -> hit=0.
- Assert reset during STROBE with 2 entries queued -> WriteC=0 next edge, queue empty, no further strobes, res_ready=1.
- Push during RELEASE while full -> count stays DEPTH, the new entry is written last, and no entry is lost or duplicated across pointer wrap.
